// File: rtl/core_regfile_loader_pkg.sv
// rtl/core_regfile_loader_pkg.sv - shared header layout, region and FSM encodings for the regfile loader
package core_regfile_loader_pkg;

  localparam int NUM_CORES      = 4;
  localparam int HDR_CORE_LSB   = 30;
  localparam int HDR_CORE_W     = 2;
  localparam int HDR_REGION_BIT = 29;
  localparam int HDR_BASE_LSB   = 12;
  localparam int HDR_BASE_W     = 12;
  localparam int HDR_LEN_LSB    = 0;
  localparam int HDR_LEN_W      = 12;

  typedef enum logic {
    REGION_INEX  = 1'b0,
    REGION_STATE = 1'b1
  } region_e;

  typedef enum logic [1:0] {
    HDR,
    PAY,
    STRT
  } state_e;

endpackage

// File: rtl/core_regfile_loader_port_demux.sv
// rtl/core_regfile_loader_port_demux.sv - registered 1-to-4 x 2-region write-port demux
module loader_port_demux
  import core_regfile_loader_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int INEX_W  = 32,
  parameter int STATE_W = 18
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  we,
  input  logic [HDR_CORE_W-1:0]                 core,
  input  region_e                               region,
  input  logic [ADDR_W-1:0]                     addr,
  input  logic [INEX_W-1:0]                     data,
  output logic [NUM_CORES-1:0]                  inex_we,
  output logic [NUM_CORES-1:0][ADDR_W-1:0]      inex_addr,
  output logic [NUM_CORES-1:0][INEX_W-1:0]      inex_data,
  output logic [NUM_CORES-1:0]                  state_we,
  output logic [NUM_CORES-1:0][ADDR_W-1:0]      state_addr,
  output logic [NUM_CORES-1:0][STATE_W-1:0]     state_data
);

  // Address/data only load on a hit so idle ports keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inex_we    <= '0;
      inex_addr  <= '0;
      inex_data  <= '0;
      state_we   <= '0;
      state_addr <= '0;
      state_data <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        inex_we[k]  <= we && (core == HDR_CORE_W'(k)) && (region == REGION_INEX);
        state_we[k] <= we && (core == HDR_CORE_W'(k)) && (region == REGION_STATE);
        if (we && (core == HDR_CORE_W'(k)) && (region == REGION_INEX)) begin
          inex_addr[k] <= addr;
          inex_data[k] <= data;
        end
        if (we && (core == HDR_CORE_W'(k)) && (region == REGION_STATE)) begin
          state_addr[k] <= addr;
          state_data[k] <= data[STATE_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/core_regfile_loader.sv
// rtl/core_regfile_loader.sv - host burst stream to per-core regfile write ports, with deferred start pulse
module core_regfile_loader
  import core_regfile_loader_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int INEX_W  = 32,
  parameter int STATE_W = 18,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  input  logic               go,
  output logic               busy,
  output logic               is_start,
  output logic [CNT_W-1:0]   wr_count,
  output logic               ran_we_InexRecur_1,
  output logic               ran_we_InexRecur_2,
  output logic               ran_we_InexRecur_3,
  output logic               ran_we_InexRecur_4,
  output logic [ADDR_W-1:0]  ran_w_addr_InexRecur_1,
  output logic [ADDR_W-1:0]  ran_w_addr_InexRecur_2,
  output logic [ADDR_W-1:0]  ran_w_addr_InexRecur_3,
  output logic [ADDR_W-1:0]  ran_w_addr_InexRecur_4,
  output logic [INEX_W-1:0]  ran_w_data_InexRecur_1,
  output logic [INEX_W-1:0]  ran_w_data_InexRecur_2,
  output logic [INEX_W-1:0]  ran_w_data_InexRecur_3,
  output logic [INEX_W-1:0]  ran_w_data_InexRecur_4,
  output logic               ran_we_state_external_1,
  output logic               ran_we_state_external_2,
  output logic               ran_we_state_external_3,
  output logic               ran_we_state_external_4,
  output logic [ADDR_W-1:0]  ran_w_addr_state_external_1,
  output logic [ADDR_W-1:0]  ran_w_addr_state_external_2,
  output logic [ADDR_W-1:0]  ran_w_addr_state_external_3,
  output logic [ADDR_W-1:0]  ran_w_addr_state_external_4,
  output logic [STATE_W-1:0] ran_w_data_state_external_1,
  output logic [STATE_W-1:0] ran_w_data_state_external_2,
  output logic [STATE_W-1:0] ran_w_data_state_external_3,
  output logic [STATE_W-1:0] ran_w_data_state_external_4
);

  state_e                 state_q, state_d;
  logic [HDR_CORE_W-1:0]  core_q, core_d;
  region_e                region_q, region_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [HDR_LEN_W-1:0]   rem_q, rem_d;
  logic                   pend_q, pend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   hs;
  logic                   wr_we;
  logic                   unused_hdr_bits;

  assign unused_hdr_bits = ^s_data[28:24];
  assign s_ready  = (state_q != STRT);
  assign hs       = s_valid && s_ready;
  assign is_start = (state_q == STRT);
  assign busy     = (state_q != HDR) || pend_q;
  assign wr_count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HDR;
      core_q   <= '0;
      region_q <= REGION_INEX;
      addr_q   <= '0;
      rem_q    <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      core_q   <= core_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    core_d   = core_q;
    region_d = region_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    wr_we    = 1'b0;
    case (state_q)
      HDR: begin
        if (hs) begin
          core_d   = s_data[HDR_CORE_LSB +: HDR_CORE_W];
          region_d = region_e'(s_data[HDR_REGION_BIT]);
          addr_d   = ADDR_W'(s_data[HDR_BASE_LSB +: HDR_BASE_W]);
          rem_d    = s_data[HDR_LEN_LSB +: HDR_LEN_W];
          state_d  = PAY;
          if (go) pend_d = 1'b1;
        end else if (go) begin
          state_d = STRT;
        end
      end
      PAY: begin
        if (go) pend_d = 1'b1;
        if (hs) begin
          wr_we  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          // A go arriving with the final word still counts toward this start.
          if (rem_q == '0) state_d = (pend_q || go) ? STRT : HDR;
          else             rem_d   = rem_q - 1'b1;
        end
      end
      STRT: begin
        pend_d  = 1'b0;
        state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  logic [NUM_CORES-1:0]              inex_we, state_we;
  logic [NUM_CORES-1:0][ADDR_W-1:0]  inex_addr, state_addr;
  logic [NUM_CORES-1:0][INEX_W-1:0]  inex_data;
  logic [NUM_CORES-1:0][STATE_W-1:0] state_data;

  loader_port_demux #(
    .ADDR_W  (ADDR_W),
    .INEX_W  (INEX_W),
    .STATE_W (STATE_W)
  ) u_demux (
    .clk        (clk),
    .rst        (rst),
    .we         (wr_we),
    .core       (core_q),
    .region     (region_q),
    .addr       (addr_q),
    .data       (INEX_W'(s_data)),
    .inex_we    (inex_we),
    .inex_addr  (inex_addr),
    .inex_data  (inex_data),
    .state_we   (state_we),
    .state_addr (state_addr),
    .state_data (state_data)
  );

  assign ran_we_InexRecur_1          = inex_we[0];
  assign ran_we_InexRecur_2          = inex_we[1];
  assign ran_we_InexRecur_3          = inex_we[2];
  assign ran_we_InexRecur_4          = inex_we[3];
  assign ran_w_addr_InexRecur_1      = inex_addr[0];
  assign ran_w_addr_InexRecur_2      = inex_addr[1];
  assign ran_w_addr_InexRecur_3      = inex_addr[2];
  assign ran_w_addr_InexRecur_4      = inex_addr[3];
  assign ran_w_data_InexRecur_1      = inex_data[0];
  assign ran_w_data_InexRecur_2      = inex_data[1];
  assign ran_w_data_InexRecur_3      = inex_data[2];
  assign ran_w_data_InexRecur_4      = inex_data[3];
  assign ran_we_state_external_1     = state_we[0];
  assign ran_we_state_external_2     = state_we[1];
  assign ran_we_state_external_3     = state_we[2];
  assign ran_we_state_external_4     = state_we[3];
  assign ran_w_addr_state_external_1 = state_addr[0];
  assign ran_w_addr_state_external_2 = state_addr[1];
  assign ran_w_addr_state_external_3 = state_addr[2];
  assign ran_w_addr_state_external_4 = state_addr[3];
  assign ran_w_data_state_external_1 = state_data[0];
  assign ran_w_data_state_external_2 = state_data[1];
  assign ran_w_data_state_external_3 = state_data[2];
  assign ran_w_data_state_external_4 = state_data[3];

endmodule

// File: tb/tb_core_regfile_loader.sv
// tb/tb_core_regfile_loader.sv - self-checking bench for core_regfile_loader
module tb_core_regfile_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        go;
  logic        busy;
  logic        is_start;
  logic [15:0] wr_count;
  logic [3:0]  d_iwe, d_swe;
  logic [11:0] d_ia [4];
  logic [11:0] d_sa [4];
  logic [31:0] d_id [4];
  logic [17:0] d_sd [4];

  always #5 clk = ~clk;

  core_regfile_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .go(go), .busy(busy), .is_start(is_start), .wr_count(wr_count),
    .ran_we_InexRecur_1(d_iwe[0]), .ran_we_InexRecur_2(d_iwe[1]),
    .ran_we_InexRecur_3(d_iwe[2]), .ran_we_InexRecur_4(d_iwe[3]),
    .ran_w_addr_InexRecur_1(d_ia[0]), .ran_w_addr_InexRecur_2(d_ia[1]),
    .ran_w_addr_InexRecur_3(d_ia[2]), .ran_w_addr_InexRecur_4(d_ia[3]),
    .ran_w_data_InexRecur_1(d_id[0]), .ran_w_data_InexRecur_2(d_id[1]),
    .ran_w_data_InexRecur_3(d_id[2]), .ran_w_data_InexRecur_4(d_id[3]),
    .ran_we_state_external_1(d_swe[0]), .ran_we_state_external_2(d_swe[1]),
    .ran_we_state_external_3(d_swe[2]), .ran_we_state_external_4(d_swe[3]),
    .ran_w_addr_state_external_1(d_sa[0]), .ran_w_addr_state_external_2(d_sa[1]),
    .ran_w_addr_state_external_3(d_sa[2]), .ran_w_addr_state_external_4(d_sa[3]),
    .ran_w_data_state_external_1(d_sd[0]), .ran_w_data_state_external_2(d_sd[1]),
    .ran_w_data_state_external_3(d_sd[2]), .ran_w_data_state_external_4(d_sd[3])
  );

  // Reference model: burst bookkeeping in plain integers
  bit          m_burst, m_pend, m_start;
  int          m_left, m_core, m_region, m_addr, m_cnt;
  bit   [3:0]  e_iwe, e_swe;
  logic [11:0] e_ia [4];
  logic [11:0] e_sa [4];
  logic [31:0] e_id [4];
  logic [17:0] e_sd [4];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_burst = 0; m_pend = 0; m_start = 0;
    m_left = 0; m_core = 0; m_region = 0; m_addr = 0; m_cnt = 0;
    e_iwe = '0; e_swe = '0;
    for (int k = 0; k < 4; k++) begin
      e_ia[k] = '0; e_sa[k] = '0; e_id[k] = '0; e_sd[k] = '0;
    end
  endtask

  task automatic check_all();
    chk("s_ready", s_ready, !m_start);
    chk("is_start", is_start, m_start);
    chk("busy", busy, m_burst || m_start || m_pend);
    chk("wr_count", wr_count, m_cnt);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("inex_we%0d", k + 1), d_iwe[k], e_iwe[k]);
      chk($sformatf("inex_addr%0d", k + 1), d_ia[k], e_ia[k]);
      chk($sformatf("inex_data%0d", k + 1), d_id[k], e_id[k]);
      chk($sformatf("state_we%0d", k + 1), d_swe[k], e_swe[k]);
      chk($sformatf("state_addr%0d", k + 1), d_sa[k], e_sa[k]);
      chk($sformatf("state_data%0d", k + 1), d_sd[k], e_sd[k]);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit g, output bit took);
    bit hs;
    s_valid = v; s_data = d; go = g;
    hs = v && !m_start;
    took = hs;
    e_iwe = '0; e_swe = '0;
    if (m_start) begin
      m_start = 0; m_pend = 0;
    end else if (hs && !m_burst) begin
      m_core = int'(d[31:30]); m_region = int'(d[29]);
      m_addr = int'(d[23:12]); m_left = int'(d[11:0]) + 1;
      m_burst = 1;
      if (g) m_pend = 1;
    end else if (hs) begin
      if (m_region == 0) begin
        e_iwe[m_core] = 1'b1; e_ia[m_core] = 12'(m_addr); e_id[m_core] = d;
      end else begin
        e_swe[m_core] = 1'b1; e_sa[m_core] = 12'(m_addr); e_sd[m_core] = d[17:0];
      end
      m_addr = (m_addr + 1) % 4096;
      m_left--;
      if (m_cnt < 65535) m_cnt++;
      if (m_left == 0) begin
        m_burst = 0;
        if (m_pend || g) begin m_start = 1; m_pend = 0; end
      end else if (g) m_pend = 1;
    end else if (g) begin
      if (m_burst) m_pend = 1;
      else m_start = 1;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit g);
    bit took;
    for (int i = 0; i < n; i++) step(1'b0, $urandom, g && (i == 0), took);
  endtask

  // Offer a word (after optional gap cycles) until accepted, bounded.
  task automatic push(input logic [31:0] w, input int gaps, input bit g);
    bit took;
    idle(gaps, 1'b0);
    took = 0;
    for (int t = 0; t < 4 && !took; t++) step(1'b1, w, g && (t == 0), took);
    chk("accept", took, 1'b1);
  endtask

  initial begin
    bit took;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; go = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    #1;
    check_all();

    push(32'h0000_5002, 0, 0);
    push(32'hAAAA_0001, 0, 0);
    push(32'hBBBB_0002, 0, 0);
    push(32'hCCCC_0003, 0, 0);
    idle(1, 0);

    push(32'hE000_0000, 0, 0);
    push(32'hFFFF_FFFF, 0, 0);
    idle(1, 0);

    push(32'h40FF_E003, 0, 0);
    push(32'h1111_1111, 2, 0);
    push(32'h2222_2222, 1, 0);
    push(32'h3333_3333, 3, 0);
    push(32'h4444_4444, 1, 0);
    idle(2, 0);

    push(32'h8000_1003, 0, 0);
    push(32'h5555_0001, 0, 0);
    push(32'h5555_0002, 0, 1);
    push(32'h5555_0003, 0, 1);
    push(32'h5555_0004, 0, 0);
    idle(2, 0);

    idle(3, 1);

    push(32'h2000_A004, 0, 0);
    push(32'h6666_0001, 0, 0);
    push(32'h6666_0002, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_all();
    push(32'h0000_3000, 0, 0);
    push(32'h0000_1234, 0, 0);
    idle(1, 0);

    for (int b = 0; b < 40; b++) begin
      logic [31:0] hdr;
      int len, base;
      len  = 1 + int'($urandom_range(0, 5));
      base = ($urandom_range(0, 3) == 0) ? 4092 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4095));
      hdr  = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom),
              12'(base), 12'(len - 1)};
      push(hdr, int'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
      for (int p = 0; p < len; p++)
        push($urandom, ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle(2, $urandom_range(0, 1) == 1);
    end
    step(1'b0, 32'h0, 1'b0, took);
    idle(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
